// File: rtl/spi_regfile_sync.sv
// spi_regfile_sync: SPI mode-0 slave register file. SCK/COPI/CS are oversampled
// in the i_clk domain; frames are command, address, then auto-incrementing data words.
module spi_regfile_sync #(
  parameter int OUTPUTS = 9,
  parameter int INPUTS  = 5,
  parameter int DW      = 8,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sck,
  input  logic                  i_copi,
  input  logic                  i_cs,
  output logic                  o_cipo,
  output logic                  o_cipo_en,
  output logic [OUTPUTS*DW-1:0] rout,
  input  logic [INPUTS*DW-1:0]  rin,
  output logic [OUTPUTS-1:0]    o_wr_stb,
  output logic [INPUTS-1:0]     o_rd_stb
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] HDR_LAST = CW'(7);
  localparam logic [CW-1:0] DAT_LAST = CW'(DW - 1);
  localparam logic [7:0]    CMD_WR   = 8'h02;
  localparam logic [7:0]    CMD_RD   = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  // Pin synchronisers and the aligned, registered edge strobes
  logic [1:0]    r_sck_s, r_copi_s, r_cs_s;
  logic          r_sck_prev, r_rise, r_fall, r_bit, r_cs_q;
  // r_vld fills with ones after reset; once full, r_cs_q reflects the real pin
  logic [2:0]    r_vld;
  // r_armed: CS has been genuinely seen high since reset, so a low CS starts a frame
  logic          r_armed;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-2:0] r_sr;
  logic [7:0]    r_cmd, r_addr;
  logic [DW-1:0] r_tx;
  logic          r_cipo, r_cipo_en;
  logic [DW-1:0] r_rout [OUTPUTS];
  logic [OUTPUTS-1:0] r_wr_stb;
  logic [INPUTS-1:0]  r_rd_stb;

  logic [DW-1:0]      w_sr_next;
  logic [7:0]         w_hdr_next;
  logic [7:0]         w_cap_addr;
  logic [DW-1:0]      w_rd_word;
  logic [INPUTS-1:0]  w_rd_hit;
  logic [OUTPUTS-1:0] w_wr_hit;

  assign w_sr_next  = {r_sr, r_bit};
  assign w_hdr_next = {r_sr[6:0], r_bit};
  // The first read word uses the address being completed; later words use r_addr
  assign w_cap_addr = (r_state == S_ADDR) ? w_hdr_next : r_addr;

  // Select the status word for the capture address; out-of-range yields zero
  always_comb begin
    w_rd_word = {DW{1'b0}};
    w_rd_hit  = {INPUTS{1'b0}};
    for (int k = 0; k < INPUTS; k++) begin
      w_rd_hit[k] = (w_cap_addr == 8'(k));
      w_rd_word   = w_rd_word | (rin[k*DW +: DW] & {DW{w_rd_hit[k]}});
    end
  end

  // Decode the write address into a one-hot select; out-of-range selects nothing
  always_comb begin
    w_wr_hit = {OUTPUTS{1'b0}};
    for (int k = 0; k < OUTPUTS; k++) begin
      w_wr_hit[k] = (r_addr == 8'(k));
    end
  end

  // Two-flop synchronisers followed by registered SCK edge strobes and aligned data/CS
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_s    <= 2'b00;
      r_copi_s   <= 2'b00;
      r_cs_s     <= 2'b11;
      r_sck_prev <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_bit      <= 1'b0;
      r_cs_q     <= 1'b1;
      r_vld      <= 3'b000;
    end else begin
      r_sck_s    <= {r_sck_s[0], i_sck};
      r_copi_s   <= {r_copi_s[0], i_copi};
      r_cs_s     <= {r_cs_s[0], i_cs};
      r_sck_prev <= r_sck_s[1];
      r_rise     <= r_sck_s[1] & ~r_sck_prev;
      r_fall     <= ~r_sck_s[1] & r_sck_prev;
      r_bit      <= r_copi_s[1];
      r_cs_q     <= r_cs_s[1];
      r_vld      <= {r_vld[1:0], 1'b1};
    end
  end

  // Frame FSM with datapath: field shifting, register writes, read capture and CIPO drive
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_cnt     <= {CW{1'b0}};
      r_sr      <= {(DW-1){1'b0}};
      r_cmd     <= 8'h00;
      r_addr    <= 8'h00;
      r_tx      <= {DW{1'b0}};
      r_cipo    <= 1'b0;
      r_cipo_en <= 1'b0;
      r_wr_stb  <= {OUTPUTS{1'b0}};
      r_rd_stb  <= {INPUTS{1'b0}};
      for (int k = 0; k < OUTPUTS; k++) begin
        r_rout[k] <= RST_VAL;
      end
    end else begin
      r_wr_stb <= {OUTPUTS{1'b0}};
      r_rd_stb <= {INPUTS{1'b0}};
      if (r_vld[2] && r_cs_q) begin
        r_armed <= 1'b1;
      end
      if (r_cs_q) begin
        // Deselect wins over any SCK strobe in the same cycle; partial words are dropped
        r_state   <= S_IDLE;
        r_cnt     <= {CW{1'b0}};
        r_cipo    <= 1'b0;
        r_cipo_en <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_armed) begin
              r_state <= S_CMD;
              r_cnt   <= {CW{1'b0}};
            end
          end
          S_CMD: begin
            if (r_rise) begin
              r_sr <= w_sr_next[DW-2:0];
              if (r_cnt == HDR_LAST) begin
                r_cmd   <= w_hdr_next;
                r_cnt   <= {CW{1'b0}};
                r_state <= S_ADDR;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
          S_ADDR: begin
            if (r_rise) begin
              r_sr <= w_sr_next[DW-2:0];
              if (r_cnt == HDR_LAST) begin
                r_cnt <= {CW{1'b0}};
                if (r_cmd == CMD_WR) begin
                  r_addr  <= w_hdr_next;
                  r_state <= S_WDATA;
                end else if (r_cmd == CMD_RD) begin
                  r_addr    <= w_hdr_next + 8'd1;
                  r_tx      <= w_rd_word;
                  r_rd_stb  <= w_rd_hit;
                  r_cipo_en <= 1'b1;
                  r_state   <= S_RDATA;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
          S_WDATA: begin
            if (r_rise) begin
              r_sr <= w_sr_next[DW-2:0];
              if (r_cnt == DAT_LAST) begin
                r_cnt <= {CW{1'b0}};
                for (int k = 0; k < OUTPUTS; k++) begin
                  if (w_wr_hit[k]) begin
                    r_rout[k] <= w_sr_next;
                  end
                end
                r_wr_stb <= w_wr_hit;
                r_addr   <= r_addr + 8'd1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
          S_RDATA: begin
            if (r_rise) begin
              if (r_cnt == DAT_LAST) begin
                r_cnt    <= {CW{1'b0}};
                r_tx     <= w_rd_word;
                r_rd_stb <= w_rd_hit;
                r_addr   <= r_addr + 8'd1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end else if (r_fall) begin
              r_cipo <= r_tx[DW-1];
              r_tx   <= {r_tx[DW-2:0], 1'b0};
            end
          end
          S_IGNORE: begin
            r_state <= S_IGNORE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < OUTPUTS; g++) begin : g_rout
      assign rout[g*DW +: DW] = r_rout[g];
    end
  endgenerate

  assign o_cipo    = r_cipo;
  assign o_cipo_en = r_cipo_en;
  assign o_wr_stb  = r_wr_stb;
  assign o_rd_stb  = r_rd_stb;

endmodule

// File: tb/tb_spi_regfile_sync.sv
// Bench for spi_regfile_sync: directed frames plus randomized frames against a
// word-level model of register contents, strobes and read data.
module tb_spi_regfile_sync;
  localparam int OUT  = 4;
  localparam int INP  = 4;
  localparam int DW   = 8;
  localparam int HALF = 6;
  localparam logic [7:0] RSTV = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, sck = 1'b0, copi = 1'b0, cs = 1'b1;
  logic cipo, cipo_en;
  logic [OUT*DW-1:0] rout;
  logic [INP*DW-1:0] rin;
  logic [OUT-1:0]    wr_stb;
  logic [INP-1:0]    rd_stb;

  spi_regfile_sync #(.OUTPUTS(OUT), .INPUTS(INP), .DW(DW), .RST_VAL(RSTV)) dut (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_copi(copi), .i_cs(cs),
    .o_cipo(cipo), .o_cipo_en(cipo_en), .rout(rout), .rin(rin),
    .o_wr_stb(wr_stb), .o_rd_stb(rd_stb)
  );

  int n_cmp = 0, n_bad = 0, viol = 0, en_miss = 0;
  logic en_forbid = 1'b1;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  logic [OUT-1:0] wr_log[$];
  logic [INP-1:0] rd_log[$];
  logic [OUT-1:0] exp_wr[$];
  logic [INP-1:0] exp_rd[$];
  logic [7:0] model_rout[OUT];
  logic [7:0] rin_w[INP];
  logic [OUT-1:0] prev_wr = '0;
  logic [INP-1:0] prev_rd = '0;

  always_comb begin
    for (int k = 0; k < INP; k++) rin[k*DW +: DW] = rin_w[k];
  end

  // Strobe logging and protocol observations, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_stb != '0) wr_log.push_back(wr_stb);
    if (rd_stb != '0) rd_log.push_back(rd_stb);
    viol <= viol + (((wr_stb != '0) && (rd_stb != '0)) ? 1 : 0)
                 + ((((wr_stb & prev_wr) != '0) || ((rd_stb & prev_rd) != '0)) ? 1 : 0)
                 + ((!cipo_en && cipo) ? 1 : 0)
                 + ((cipo_en && en_forbid) ? 1 : 0);
    prev_wr <= wr_stb;
    prev_rd <= rd_stb;
  end

  // SPI master: sends nbits of tx_q; optional reset pulse before bit rst_at; optional CS/SCK race on last bit
  task automatic spi_run(input int nbits, input bit is_read, input int rst_at, input bit race);
    logic [7:0] byt;
    logic [7:0] rxb;
    rx_q.delete();
    en_miss = 0;
    rxb = 8'h00;
    sck = 1'b0;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      byt = tx_q[i/8];
      copi = byt[7 - (i % 8)];
      repeat (HALF) @(negedge clk);
      if (race && (i == nbits - 1)) cs = 1'b1;
      sck = 1'b1;
      if (is_read && i >= 16) begin
        rxb = {rxb[6:0], cipo};
        if (!cipo_en) en_miss++;
        if (i % 8 == 7) rx_q.push_back(rxb);
      end
      if (is_read && i == 15) en_forbid = 1'b0;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    copi = 1'b0;
    repeat (10) @(negedge clk);
    en_forbid = 1'b1;
  endtask

  // Word-level model of one complete frame: register updates, expected strobes and read bytes
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nwords);
    int a;
    exp_wr.delete();
    exp_rd.delete();
    exp_rx.delete();
    if (cmd == 8'h02) begin
      for (int w = 0; w < nwords; w++) begin
        a = (int'(addr) + w) % 256;
        if (a < OUT) begin
          model_rout[a] = tx_q[2 + w];
          exp_wr.push_back({{(OUT-1){1'b0}}, 1'b1} << a);
        end
      end
    end else if (cmd == 8'h01) begin
      for (int w = 0; w <= nwords; w++) begin
        a = (int'(addr) + w) % 256;
        if (a < INP) exp_rd.push_back({{(INP-1){1'b0}}, 1'b1} << a);
        if (w < nwords) exp_rx.push_back((a < INP) ? rin_w[a] : 8'h00);
      end
    end
  endtask

  task automatic test_reset();
    int ws, rs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < OUT; k++) begin
      n_cmp++;
      if (rout[k*DW +: DW] !== 8'h5A) begin
        n_bad++; $display("FAIL reset_rout[%0d] got %h want 5a", k, rout[k*DW +: DW]);
      end
    end
    n_cmp++;
    if ({cipo, cipo_en, wr_stb, rd_stb} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %b want 0", {cipo, cipo_en, wr_stb, rd_stb});
    end
    // Reset asserted in the middle of a write burst; rest of that frame must be ignored
    ws = wr_log.size(); rs = rd_log.size();
    tx_q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    spi_run(48, 1'b0, 20, 1'b0);
    for (int k = 0; k < OUT; k++) model_rout[k] = RSTV;
    for (int k = 0; k < OUT; k++) begin
      n_cmp++;
      if (rout[k*DW +: DW] !== 8'h5A) begin
        n_bad++; $display("FAIL midreset_rout[%0d] got %h want 5a", k, rout[k*DW +: DW]);
      end
    end
    n_cmp++;
    if (wr_log.size() != ws || rd_log.size() != rs) begin
      n_bad++; $display("FAIL midreset_strobes got %0d want 0", wr_log.size() - ws + rd_log.size() - rs);
    end
    ws = wr_log.size();
    tx_q = {8'h02, 8'h01, 8'hA5};
    spi_run(24, 1'b0, -1, 1'b0);
    model_rout[1] = 8'hA5;
    n_cmp++;
    if (rout[1*DW +: DW] !== 8'hA5) begin
      n_bad++; $display("FAIL postreset_w1 got %h want a5", rout[1*DW +: DW]);
    end
    n_cmp++;
    if (wr_log.size() != ws + 1 || wr_log[ws] !== 4'b0010) begin
      n_bad++; $display("FAIL postreset_stb got %0d entries want 1 x 0010", wr_log.size() - ws);
    end
  endtask

  task automatic test_single_write();
    int ws, v0;
    ws = wr_log.size(); v0 = viol;
    tx_q = {8'h02, 8'h03, 8'hC3};
    spi_run(24, 1'b0, -1, 1'b0);
    model_rout[3] = 8'hC3;
    for (int k = 0; k < OUT; k++) begin
      n_cmp++;
      if (rout[k*DW +: DW] !== model_rout[k]) begin
        n_bad++; $display("FAIL single_rout[%0d] got %h want %h", k, rout[k*DW +: DW], model_rout[k]);
      end
    end
    n_cmp++;
    if (wr_log.size() != ws + 1 || wr_log[ws] !== 4'b1000) begin
      n_bad++; $display("FAIL single_stb got %0d entries want 1 x 1000", wr_log.size() - ws);
    end
    n_cmp++;
    if (viol != v0) begin
      n_bad++; $display("FAIL single_protocol got %0d want 0", viol - v0);
    end
  endtask

  task automatic test_burst_write();
    int ws;
    ws = wr_log.size();
    tx_q = {8'h02, 8'h02, 8'h11, 8'h22, 8'h33};
    spi_run(40, 1'b0, -1, 1'b0);
    model_rout[2] = 8'h11;
    model_rout[3] = 8'h22;
    for (int k = 0; k < OUT; k++) begin
      n_cmp++;
      if (rout[k*DW +: DW] !== model_rout[k]) begin
        n_bad++; $display("FAIL burstw_rout[%0d] got %h want %h", k, rout[k*DW +: DW], model_rout[k]);
      end
    end
    n_cmp++;
    if (wr_log.size() != ws + 2 || wr_log[ws] !== 4'b0100 || wr_log[ws+1] !== 4'b1000) begin
      n_bad++; $display("FAIL burstw_stb got %0d entries want 0100,1000", wr_log.size() - ws);
    end
  endtask

  task automatic test_burst_read();
    int rs, v0;
    rin_w[0] = 8'hDD; rin_w[1] = 8'hCC; rin_w[2] = 8'hBB; rin_w[3] = 8'hAA;
    rs = rd_log.size(); v0 = viol;
    tx_q = {8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
    spi_run(40, 1'b1, -1, 1'b0);
    n_cmp++;
    if (rx_q.size() != 3 || rx_q[0] !== 8'hBB || rx_q[1] !== 8'hAA || rx_q[2] !== 8'h00) begin
      n_bad++; $display("FAIL burstr_data got %0d bytes first %h want bb,aa,00", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    n_cmp++;
    if (rd_log.size() != rs + 2 || rd_log[rs] !== 4'b0100 || rd_log[rs+1] !== 4'b1000) begin
      n_bad++; $display("FAIL burstr_stb got %0d entries want 0100,1000", rd_log.size() - rs);
    end
    n_cmp++;
    if (en_miss != 0 || viol != v0) begin
      n_bad++; $display("FAIL burstr_enable got miss=%0d viol=%0d want 0,0", en_miss, viol - v0);
    end
  endtask

  task automatic test_abort();
    int ws;
    ws = wr_log.size();
    tx_q = {8'h02, 8'h00, 8'hF0};
    spi_run(21, 1'b0, -1, 1'b0);
    n_cmp++;
    if (rout[0 +: DW] !== model_rout[0] || wr_log.size() != ws) begin
      n_bad++; $display("FAIL abort got w0=%h stb=%0d want %h,0", rout[0 +: DW], wr_log.size() - ws, model_rout[0]);
    end
    tx_q = {8'h02, 8'h00, 8'h3C};
    spi_run(24, 1'b0, -1, 1'b0);
    model_rout[0] = 8'h3C;
    n_cmp++;
    if (rout[0 +: DW] !== 8'h3C || wr_log.size() != ws + 1) begin
      n_bad++; $display("FAIL abort_next got w0=%h stb=%0d want 3c,1", rout[0 +: DW], wr_log.size() - ws);
    end
  endtask

  task automatic test_illegal();
    int ws, rs, v0;
    ws = wr_log.size(); rs = rd_log.size(); v0 = viol;
    tx_q = {8'h7F, 8'h00, 8'hFF};
    spi_run(24, 1'b0, -1, 1'b0);
    n_cmp++;
    if (rout[0 +: DW] !== model_rout[0] || wr_log.size() != ws || rd_log.size() != rs) begin
      n_bad++; $display("FAIL illegal_write got w0=%h want %h", rout[0 +: DW], model_rout[0]);
    end
    n_cmp++;
    if (viol != v0) begin
      n_bad++; $display("FAIL illegal_enable got %0d want 0", viol - v0);
    end
  endtask

  task automatic test_cs_race();
    int ws;
    ws = wr_log.size();
    tx_q = {8'h02, 8'h01, 8'h77};
    spi_run(24, 1'b0, -1, 1'b1);
    n_cmp++;
    if (rout[1*DW +: DW] !== model_rout[1] || wr_log.size() != ws) begin
      n_bad++; $display("FAIL cs_race got w1=%h stb=%0d want %h,0", rout[1*DW +: DW], wr_log.size() - ws, model_rout[1]);
    end
  endtask

  task automatic test_random();
    int ws, rs, v0, nw, extra, sel;
    logic [7:0] cmd, addr;
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < INP; k++) rin_w[k] = 8'($urandom);
      sel = $urandom_range(0, 2);
      cmd = (sel == 0) ? 8'h02 : (sel == 1) ? 8'h01 : 8'(8'h03 + $urandom_range(0, 250));
      addr = ($urandom_range(0, 3) == 0) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom_range(0, 5));
      nw = $urandom_range(0, 3);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      tx_q = {cmd, addr};
      for (int w = 0; w <= nw; w++) tx_q.push_back(8'($urandom));
      ws = wr_log.size(); rs = rd_log.size(); v0 = viol;
      model_frame(cmd, addr, nw);
      spi_run(16 + 8*nw + extra, cmd == 8'h01, -1, 1'b0);
      for (int k = 0; k < OUT; k++) begin
        n_cmp++;
        if (rout[k*DW +: DW] !== model_rout[k]) begin
          n_bad++; $display("FAIL rand%0d_rout[%0d] got %h want %h", it, k, rout[k*DW +: DW], model_rout[k]);
        end
      end
      n_cmp++;
      if (wr_log.size() - ws != exp_wr.size()) begin
        n_bad++; $display("FAIL rand%0d_wrcount got %0d want %0d", it, wr_log.size() - ws, exp_wr.size());
      end else begin
        for (int i = 0; i < exp_wr.size(); i++) begin
          n_cmp++;
          if (wr_log[ws+i] !== exp_wr[i]) begin
            n_bad++; $display("FAIL rand%0d_wrstb got %b want %b", it, wr_log[ws+i], exp_wr[i]);
          end
        end
      end
      n_cmp++;
      if (rd_log.size() - rs != exp_rd.size()) begin
        n_bad++; $display("FAIL rand%0d_rdcount got %0d want %0d", it, rd_log.size() - rs, exp_rd.size());
      end else begin
        for (int i = 0; i < exp_rd.size(); i++) begin
          n_cmp++;
          if (rd_log[rs+i] !== exp_rd[i]) begin
            n_bad++; $display("FAIL rand%0d_rdstb got %b want %b", it, rd_log[rs+i], exp_rd[i]);
          end
        end
      end
      if (cmd == 8'h01) begin
        for (int i = 0; i < exp_rx.size(); i++) begin
          n_cmp++;
          if (i >= rx_q.size() || rx_q[i] !== exp_rx[i]) begin
            n_bad++; $display("FAIL rand%0d_rx[%0d] got %h want %h", it, i, (i < rx_q.size()) ? rx_q[i] : 8'hXX, exp_rx[i]);
          end
        end
      end
      n_cmp++;
      if (viol != v0 || en_miss != 0) begin
        n_bad++; $display("FAIL rand%0d_protocol got viol=%0d miss=%0d want 0,0", it, viol - v0, en_miss);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < INP; k++) rin_w[k] = 8'h00;
    for (int k = 0; k < OUT; k++) model_rout[k] = RSTV;
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_illegal();
    test_cs_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_regfile_sync.md
# spi_regfile_sync

Single-clock SPI slave register file with parametrised data width and channel counts. SPI pins are oversampled into the system clock domain, and burst transfers auto-increment the address. It bridges an external SPI master to `OUTPUTS` writable control registers and `INPUTS` readable status words. All logic runs on `i_clk`; `i_sck` is treated as data, never as a clock.

## Interface
- `OUTPUTS`, 9: number of writable registers, 1..256, at addresses 0..OUTPUTS-1.
- `INPUTS`, 5: number of readable words, 1..256, at addresses 0..INPUTS-1.
- `DW`, 8: register width in bits; one of 8, 16, 32.
- `RST_VAL`, 0: reset value of every `rout` word (DW bits).

Ports:
- `i_clk`  in  1: system clock. Requires f_clk ≥ 8 × f_sck.
- `i_rst`  in  1: synchronous reset, active-high.
- `i_sck`  in  1: SPI clock, mode 0 (CPOL=0, CPHA=0). Asynchronous to `i_clk`.
- `i_copi`  in  1: SPI data in, MSB-first.
- `i_cs`  in  1: chip select, active-low. 1 = deselected.
- `o_cipo`  out  1: SPI data out, MSB-first. 0 when `o_cipo_en`=0.
- `o_cipo_en`  out  1: output enable for the pad tristate, which lives at top level.
- `rout`  out  OUTPUTS*DW: register contents. Word k is at [k*DW +: DW].
- `rin`  in  INPUTS*DW: status words. Word k is at [k*DW +: DW].
- `o_wr_stb`  out  OUTPUTS: one-cycle pulse on bit k when word k is written.
- `o_rd_stb`  out  INPUTS: one-cycle pulse on bit k when word k is captured for readout.

## Operation
- **Input synchronisation:** `i_sck`, `i_copi` and `i_cs` each pass through a 2-flop synchroniser. SCK rise and fall are detected as single-cycle strobes from the synchronised value versus its previous value.
- **Frame format** (CS low): command byte (8 bits), then address byte (8 bits), then zero or more data words of DW bits each. All fields are MSB-first.
- **Commands:** 0x02 = write, 0x01 = read. Any other command enters IGNORE.
- **State machine:** IDLE → CMD → ADDR → {WDATA | RDATA | IGNORE}.
  - IDLE → CMD when synchronised CS falls.
  - CMD → ADDR after the 8th SCK rise.
  - ADDR → WDATA or RDATA after the 8th SCK rise, according to the latched command.
  - WDATA and RDATA loop per word.
  - Any state → IDLE on synchronised CS high, evaluated with priority over all SCK strobes in the same cycle.
- **Sampling and shifting:** bits are sampled on SCK rise. `o_cipo` updates on SCK fall.
- **Bit counter:** counts 0..7 for CMD/ADDR and 0..DW-1 for data words, resetting to 0 at each field boundary.
- **Write:** on the SCK rise of a word's last bit, the assembled word is written to `rout[addr]` and `o_wr_stb[addr]` pulses, both in the cycle after the strobe. Then addr = addr+1, modulo 256.
  - addr ≥ OUTPUTS: no write and no strobe; addr still increments.
- **Read:** `rin[addr]` is captured into the DW-bit shift register in the cycle after the address byte's last-bit rise, and again after each read word's last-bit rise. `o_rd_stb[addr]` pulses in the same cycle as the capture. Then addr increments.
  - addr ≥ INPUTS: all-zero word captured and no strobe.
- **Read output:** the first MSB appears on `o_cipo` at the SCK fall following the capture, which is before the master's first data rise.
- **Output enable:** `o_cipo_en` = 1 in RDATA only. `o_cipo` = 0 in all other states.
- **Partial words:** a partial word at CS deassertion is discarded. No write and no strobe occur.
- **IGNORE:** no writes, no strobes, `o_cipo_en`=0, until CS deasserts.

## Timing
- **Reset** (`i_rst`=1 at `i_clk` rise), applied next cycle:
  - `rout` = all words RST_VAL.
  - `o_cipo`=0, `o_cipo_en`=0, `o_wr_stb`=0, `o_rd_stb`=0.
  - State IDLE; counters, address and shift registers cleared; synchronisers cleared, with deselected CS taken as 1.
- **Reset mid-frame:** the frame is aborted. The FSM stays IDLE until CS goes high and then low again, so the remainder of an in-progress frame is not decoded.
- **Pin-to-strobe latency:** 2 cycles of synchroniser plus 1 cycle of edge detect. A write commit lands 4 `i_clk` cycles after the physical SCK edge.
- **CS timing:** CS high for ≥ 3 `i_clk` cycles is required between frames. A CS fall with SCK high is illegal, and behaviour is undefined.
- **Simultaneous events:**
  - CS rise in the same synchronised cycle as a last-bit rise: CS wins and the word is dropped.
  - `i_rst` overrides everything.
- **Strobes:** `o_wr_stb` and `o_rd_stb` are never asserted for more than one cycle per word and never both in one cycle.

## Test plan
- **Reset:** assert `i_rst` during a write burst with RST_VAL=0x5A → all `rout`=0x5A, no strobes; the next full frame after CS toggles works.
- **Single write (DW=8):** frame 0x02, 0x03, 0xC3 → `rout` word 3 = 0xC3, `o_wr_stb`=1<<3 for one cycle, other words unchanged.
- **Burst write (DW=16, OUTPUTS=4):** frame 0x02, 0x02, then 0x1111, 0x2222, 0x3333 → word2=0x1111, word3=0x2222, address 4 dropped with no strobe, and word0/word1 unchanged.
- **Burst read:** `rin` = {0xDD,0xCC,0xBB,0xAA} at INPUTS=4, DW=8; frame 0x01, 0x02, then 3 dummy bytes → `o_cipo` returns 0xBB, 0xAA, 0x00, `o_rd_stb` pulses bits 2 then 3, and `o_cipo_en` is high only during the data bytes.
- **Abort:** CS rises after 5 bits of a write data word → no `rout` change, no strobe, FSM returns to IDLE; an immediate following frame succeeds.
- **Illegal command:** command 0x7F, address 0x00, 0xFF → no write, `o_cipo_en`=0 for the whole frame.
